// File: rtl/score_pkg.sv
// Shared types and constants for the penalty score path feeding the score sprite.
package score_pkg;

    localparam int SCORE_W = 3;
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(7);

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        COOLDOWN  = 2'd1,
        GAME_OVER = 2'd2
    } score_state_t;

    // Saturating increment; the score never wraps from MAX_SCORE back to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == MAX_SCORE) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-side bundle of score_keeper: event pulses in, frame-synced score and flags out.
// Handshake: all inputs are single-cycle pulses sampled on clk_in; no backpressure exists.
interface score_keeper_if #(
    parameter int CD_W = 6
);
    import score_pkg::*;

    logic               new_frame_in;
    logic               collision_in;
    logic               clear_in;
    logic [SCORE_W-1:0] score_out;
    logic               hit_pulse_out;
    logic               cooldown_out;
    logic               game_over_out;
    score_state_t       state_dbg;
    logic [CD_W-1:0]    cd_cnt_dbg;

    modport master (
        output new_frame_in, collision_in, clear_in,
        input  score_out, hit_pulse_out, cooldown_out, game_over_out, state_dbg, cd_cnt_dbg
    );

    modport slave (
        input  new_frame_in, collision_in, clear_in,
        output score_out, hit_pulse_out, cooldown_out, game_over_out, state_dbg, cd_cnt_dbg
    );

endinterface

// File: rtl/frame_cooldown_timer.sv
// Frame-tick down-counter: load wins over tick, expire flags the tick that takes it from 1 to 0.
module frame_cooldown_timer #(
    parameter int CD_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CD_W-1:0] load_value,
    input  logic            tick,
    output logic [CD_W-1:0] cd_cnt,
    output logic            expire
);

    logic [CD_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign cd_cnt = cnt;
    assign expire = tick && !load && (cnt == CD_W'(1));

endmodule

// File: rtl/score_keeper.sv
// Counts accepted collisions with per-hit frame cooldown and publishes the score at frame starts.
module score_keeper
    import score_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 30,
    parameter int CD_W            = 6
) (
    input  logic          clk_in,
    input  logic          rst_in,
    score_keeper_if.slave sk
);

    score_state_t       state, state_next;
    logic [SCORE_W-1:0] count, count_next;
    logic [SCORE_W-1:0] score_q;
    logic               hit_q, hit_next;
    logic               cooldown_q, game_over_q;
    logic               tmr_load;
    logic [CD_W-1:0]    tmr_load_value;
    logic [CD_W-1:0]    cd_cnt;
    logic               tmr_expire;

    frame_cooldown_timer #(.CD_W(CD_W)) u_timer (
        .clk        (clk_in),
        .rst        (rst_in),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .tick       (sk.new_frame_in),
        .cd_cnt     (cd_cnt),
        .expire     (tmr_expire)
    );

    always_comb begin
        state_next     = state;
        count_next     = count;
        hit_next       = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        if (sk.clear_in) begin
            state_next = ARMED;
            count_next = '0;
            tmr_load   = 1'b1;
        end else begin
            case (state)
                ARMED: begin
                    if (sk.collision_in) begin
                        hit_next   = 1'b1;
                        count_next = sat_inc(count);
                        if (count_next == MAX_SCORE) begin
                            state_next = GAME_OVER;
                        end else if (COOLDOWN_FRAMES != 0) begin
                            state_next     = COOLDOWN;
                            tmr_load       = 1'b1;
                            tmr_load_value = CD_W'(COOLDOWN_FRAMES);
                        end
                    end
                end
                COOLDOWN: begin
                    if (tmr_expire) state_next = ARMED;
                end
                GAME_OVER: begin
                    count_next = MAX_SCORE;
                end
                default: state_next = ARMED;
            endcase
        end
    end

    // score_q samples the pre-update count, so a same-cycle hit shows one frame later.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= ARMED;
            count       <= '0;
            score_q     <= '0;
            hit_q       <= 1'b0;
            cooldown_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            hit_q       <= hit_next;
            cooldown_q  <= (state_next == COOLDOWN);
            game_over_q <= (state_next == GAME_OVER);
            if (sk.clear_in) begin
                score_q <= '0;
            end else if (sk.new_frame_in) begin
                score_q <= count;
            end
        end
    end

    assign sk.score_out     = score_q;
    assign sk.hit_pulse_out = hit_q;
    assign sk.cooldown_out  = cooldown_q;
    assign sk.game_over_out = game_over_q;
    assign sk.state_dbg     = state;
    assign sk.cd_cnt_dbg    = cd_cnt;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with cooldown of 30, 2 and 0 frames.
module tb_score_keeper;
    import score_pkg::*;

    logic clk_in;
    logic rst_in;
    int   n_checks;
    int   n_fail;

    score_keeper_if #(.CD_W(6)) if_a ();
    score_keeper_if #(.CD_W(6)) if_b ();
    score_keeper_if #(.CD_W(6)) if_z ();

    score_keeper #(.COOLDOWN_FRAMES(30), .CD_W(6)) u_a (.clk_in(clk_in), .rst_in(rst_in), .sk(if_a.slave));
    score_keeper #(.COOLDOWN_FRAMES(2),  .CD_W(6)) u_b (.clk_in(clk_in), .rst_in(rst_in), .sk(if_b.slave));
    score_keeper #(.COOLDOWN_FRAMES(0),  .CD_W(6)) u_z (.clk_in(clk_in), .rst_in(rst_in), .sk(if_z.slave));

    // clock / reset
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int score, input int hit, input int cd, input int go);
        chk({tag, ".score"}, 32'(if_a.score_out), 32'(score));
        chk({tag, ".hit"}, 32'(if_a.hit_pulse_out), 32'(hit));
        chk({tag, ".cool"}, 32'(if_a.cooldown_out), 32'(cd));
        chk({tag, ".gover"}, 32'(if_a.game_over_out), 32'(go));
    endtask

    task automatic chk_b(input string tag, input int score, input int hit, input int cd, input int go);
        chk({tag, ".score"}, 32'(if_b.score_out), 32'(score));
        chk({tag, ".hit"}, 32'(if_b.hit_pulse_out), 32'(hit));
        chk({tag, ".cool"}, 32'(if_b.cooldown_out), 32'(cd));
        chk({tag, ".gover"}, 32'(if_b.game_over_out), 32'(go));
    endtask

    task automatic chk_z(input string tag, input int score, input int hit, input int cd, input int go);
        chk({tag, ".score"}, 32'(if_z.score_out), 32'(score));
        chk({tag, ".hit"}, 32'(if_z.hit_pulse_out), 32'(hit));
        chk({tag, ".cool"}, 32'(if_z.cooldown_out), 32'(cd));
        chk({tag, ".gover"}, 32'(if_z.game_over_out), 32'(go));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_in   = 1'b1;
        {if_a.new_frame_in, if_a.collision_in, if_a.clear_in} = 3'b000;
        {if_b.new_frame_in, if_b.collision_in, if_b.clear_in} = 3'b000;
        {if_z.new_frame_in, if_z.collision_in, if_z.clear_in} = 3'b000;

        repeat (3) tick();
        chk_a("rst_a", 0, 0, 0, 0);
        chk_b("rst_b", 0, 0, 0, 0);
        chk_z("rst_z", 0, 0, 0, 0);
        chk("rst_state", 32'(u_a.sk.state_dbg), 32'(ARMED));
        rst_in = 1'b0;
        tick();

        // idle frames: nothing changes
        for (int i = 0; i < 3; i++) begin
            if_a.new_frame_in = 1'b1;
            tick();
            if_a.new_frame_in = 1'b0;
            chk_a("idle_frame", 0, 0, 0, 0);
            tick();
            chk_a("idle_gap", 0, 0, 0, 0);
        end

        // cooldown of 2: repeated collisions are ignored until it expires
        if_b.collision_in = 1'b1;
        tick();
        chk_b("b_hit1", 0, 1, 1, 0);
        tick();
        chk_b("b_ign1", 0, 0, 1, 0);
        if_b.new_frame_in = 1'b1;
        tick();
        if_b.new_frame_in = 1'b0;
        chk_b("b_f1", 1, 0, 1, 0);
        chk("b_f1.cd", 32'(if_b.cd_cnt_dbg), 32'd1);
        tick();
        tick();
        chk_b("b_ign2", 1, 0, 1, 0);
        if_b.new_frame_in = 1'b1;
        tick();
        if_b.new_frame_in = 1'b0;
        chk_b("b_f2", 1, 0, 0, 0);
        chk("b_f2.state", 32'(if_b.state_dbg), 32'(ARMED));
        tick();
        chk_b("b_hit2", 1, 1, 1, 0);
        if_b.collision_in = 1'b0;
        if_b.new_frame_in = 1'b1;
        tick();
        chk_b("b_f3", 2, 0, 1, 0);
        if_b.new_frame_in = 1'b0;
        tick();
        if_b.new_frame_in = 1'b1;
        tick();
        if_b.new_frame_in = 1'b0;
        chk_b("b_f4", 2, 0, 0, 0);

        // collision and frame in the same cycle: pre-increment count is published
        if_b.collision_in = 1'b1;
        if_b.new_frame_in = 1'b1;
        tick();
        if_b.collision_in = 1'b0;
        if_b.new_frame_in = 1'b0;
        chk_b("b_same", 2, 1, 1, 0);
        chk("b_same.cd", 32'(if_b.cd_cnt_dbg), 32'd2);
        tick();
        if_b.new_frame_in = 1'b1;
        tick();
        if_b.new_frame_in = 1'b0;
        chk_b("b_after", 3, 0, 1, 0);

        // no cooldown: 9 spaced collisions saturate at 7
        for (int k = 1; k <= 9; k++) begin
            if_z.collision_in = 1'b1;
            tick();
            if_z.collision_in = 1'b0;
            chk_z($sformatf("z_hit%0d", k), 0, (k <= 7) ? 1 : 0, 0, (k >= 7) ? 1 : 0);
            tick();
            tick();
        end
        if_z.new_frame_in = 1'b1;
        tick();
        if_z.new_frame_in = 1'b0;
        chk_z("z_frame", 7, 0, 0, 1);
        chk("z_go.state", 32'(if_z.state_dbg), 32'(GAME_OVER));

        // clear beats collision in GAME_OVER
        if_z.clear_in     = 1'b1;
        if_z.collision_in = 1'b1;
        tick();
        if_z.clear_in     = 1'b0;
        if_z.collision_in = 1'b0;
        chk_z("z_clear", 0, 0, 0, 0);
        chk("z_clear.state", 32'(if_z.state_dbg), 32'(ARMED));
        if_z.new_frame_in = 1'b1;
        tick();
        if_z.new_frame_in = 1'b0;
        chk_z("z_clear_frame", 0, 0, 0, 0);

        // 30-frame cooldown: hit at cycle 10, frame at cycle 20
        if_a.collision_in = 1'b1;
        tick();
        if_a.collision_in = 1'b0;
        chk_a("a_hit", 0, 1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_a("a_wait", 0, 0, 1, 0);
        end
        if_a.new_frame_in = 1'b1;
        tick();
        if_a.new_frame_in = 1'b0;
        chk_a("a_frame", 1, 0, 1, 0);
        chk("a_frame.cd", 32'(if_a.cd_cnt_dbg), 32'd29);
        if_a.collision_in = 1'b1;
        tick();
        if_a.collision_in = 1'b0;
        chk_a("a_ignored", 1, 0, 1, 0);
        if_a.new_frame_in = 1'b1;
        tick();
        if_a.new_frame_in = 1'b0;
        chk_a("a_frame2", 1, 0, 1, 0);

        // asynchronous reset mid-cooldown, checked before the next clock edge
        rst_in = 1'b1;
        #2;
        chk_a("a_async_rst", 0, 0, 0, 0);
        chk("a_async_rst.state", 32'(if_a.state_dbg), 32'(ARMED));
        chk("a_async_rst.cd", 32'(if_a.cd_cnt_dbg), 32'd0);
        chk_b("b_async_rst", 0, 0, 0, 0);
        tick();
        rst_in = 1'b0;
        tick();
        chk_a("a_post_rst", 0, 0, 0, 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
